// File: rtl/mult_pipelined_if.sv
// rtl/mult_pipelined_if.sv - operand/result bundle for the registered multiplier
interface mult_pipelined_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               valid_in;
    logic [2*WIDTH-1:0] r;
    logic               valid_out;

    modport master (
        output a,
        output b,
        output valid_in,
        input  r,
        input  valid_out
    );

    modport slave (
        input  a,
        input  b,
        input  valid_in,
        output r,
        output valid_out
    );
endinterface

// File: rtl/mult_pipelined.sv
// rtl/mult_pipelined.sv - unsigned WIDTHxWIDTH multiplier, operands registered, product combinational
module mult_pipelined #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    mult_pipelined_if.slave   bus
);
    localparam int HALF = WIDTH / 2;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            valid_q <= bus.valid_in;
        end
    end

    // Half-width partial product as a shift-and-add array: one gated row per multiplier bit.
    function automatic logic [WIDTH-1:0] partial_product(
        input logic [HALF-1:0] x,
        input logic [HALF-1:0] y
    );
        logic [WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < HALF; i++) begin
            if (y[i]) begin
                acc = acc + ({{HALF{1'b0}}, x} << i);
            end
        end
        return acc;
    endfunction

    logic [WIDTH-1:0] pp_ll;
    logic [WIDTH-1:0] pp_lh;
    logic [WIDTH-1:0] pp_hl;
    logic [WIDTH-1:0] pp_hh;
    logic [WIDTH:0]   mid_sum;

    assign pp_ll = partial_product(a_q[HALF-1:0],     b_q[HALF-1:0]);
    assign pp_lh = partial_product(a_q[HALF-1:0],     b_q[WIDTH-1:HALF]);
    assign pp_hl = partial_product(a_q[WIDTH-1:HALF], b_q[HALF-1:0]);
    assign pp_hh = partial_product(a_q[WIDTH-1:HALF], b_q[WIDTH-1:HALF]);

    // Cross terms summed one bit wider so their carry reaches bit WIDTH+HALF.
    assign mid_sum = {1'b0, pp_lh} + {1'b0, pp_hl};

    assign bus.r = {pp_hh, {WIDTH{1'b0}}}
                 + ({{(WIDTH-1){1'b0}}, mid_sum} << HALF)
                 + {{WIDTH{1'b0}}, pp_ll};

    assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_mult_pipelined.sv
// tb/tb_mult_pipelined.sv - self-checking bench for mult_pipelined against a 64-bit arithmetic model
module tb_mult_pipelined;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mult_pipelined_if #(.WIDTH(32)) m ();

    mult_pipelined #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = {32'd0, x};
        ye = {32'd0, y};
        return xe * ye;
    endfunction

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge: drive, take one rising edge, sample at the next falling edge.
    task automatic apply(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic vv);
        m.a        = av;
        m.b        = bv;
        m.valid_in = vv;
        @(posedge clk);
        @(negedge clk);
        check64(tag, m.r, ref_mul(av, bv));
        check1({tag, "_valid"}, m.valid_out, vv);
    endtask

    initial begin
        logic [31:0] sa;
        logic [31:0] sb;
        logic        sv;

        m.a        = 32'd7;
        m.b        = 32'd9;
        m.valid_in = 1'b1;
        #1 reset = 1'b1;
        #1;
        check64("reset_r", m.r, 64'd0);
        check1("reset_valid", m.valid_out, 1'b0);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check64("first_after_reset", m.r, 64'd63);
        check1("first_after_reset_valid", m.valid_out, 1'b1);

        apply("seq_3x5", 32'd3, 32'd5, 1'b1);
        check64("seq_3x5_const", m.r, 64'd15);
        m.a = 32'd4;
        #2;
        check64("hold_between_edges", m.r, 64'd15);
        @(negedge clk);

        apply("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check64("max_max_const", m.r, 64'hFFFF_FFFE_0000_0001);
        apply("max_zero", 32'hFFFF_FFFF, 32'd0, 1'b1);
        apply("zero_max", 32'd0, 32'hFFFF_FFFF, 1'b1);
        apply("mid_carry", 32'h0001_0000, 32'h0001_0000, 1'b1);
        check64("mid_carry_const", m.r, 64'h0000_0001_0000_0000);
        apply("cross1", 32'h0000_FFFF, 32'hFFFF_0000, 1'b1);
        check64("cross1_const", m.r, 64'h0000_FFFE_0001_0000);
        apply("cross2", 32'hFFFF_0001, 32'h0001_FFFF, 1'b1);
        apply("cross_both_max_mid", 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b1);

        apply("vtog_1", 32'd11, 32'd13, 1'b1);
        apply("vtog_0", 32'd17, 32'd19, 1'b0);
        apply("vtog_1b", 32'd23, 32'd29, 1'b1);

        sa = 32'd0;
        sb = 32'd0;
        for (int i = 0; i < 100; i++) begin
            sv = 1'($urandom_range(0, 1));
            apply("stream", sa, sb, sv);
            sa = sa + 32'h2345_6789;
            sb = sb + 32'h3456_7891;
        end

        for (int i = 0; i < 40; i++) begin
            apply("random", $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        apply("pre_midreset", 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        #2 reset = 1'b1;
        #1;
        check64("midreset_r", m.r, 64'd0);
        check1("midreset_valid", m.valid_out, 1'b0);
        #1 reset = 1'b0;
        check64("midreset_released_r", m.r, 64'd0);
        @(negedge clk);
        apply("post_midreset", 32'hCAFE_F00D, 32'h0BAD_1DEA, 1'b1);
        apply("post_midreset_rand", $urandom, $urandom, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
